glb_core_strm_switch: RTL

GLB_CORE_STRM_SWITCH -- requirements
Module: glb_core_strm_switch

---
 rtl/glb_core_strm_switch.sv | 118 +++++++++++
 1 files changed

// File: rtl/glb_core_strm_switch.sv
// Global-buffer stream switch: routes local DMA and router requests to the
// local bank or onward to the strm router, and steers bank read data back to
// whichever side issued the read.
// Optional feature macro: GLB_STRM_SWITCH_PERF_CNT_EN adds perf_conflict_cnt.
module glb_core_strm_switch #(
    parameter int ADDR_WIDTH          = 22,
    parameter int TILE_SEL_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 64,
    parameter int RD_LATENCY          = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0]     glb_tile_id,
    input  logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] dma_req,
    output logic                               dma_req_ready,
    input  logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] rtr_req,
    output logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] fwd_req,
    output logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] bank_req,
    input  logic [DATA_WIDTH-1:0]              bank_rd_data,
    output logic [DATA_WIDTH:0]                dma_rsp,
`ifdef GLB_STRM_SWITCH_PERF_CNT_EN
    output logic [DATA_WIDTH:0]                rtr_rsp,
    output logic [31:0]                        perf_conflict_cnt
`else
    output logic [DATA_WIDTH:0]                rtr_rsp
`endif
);

    localparam int REQ_W   = 2 + ADDR_WIDTH + DATA_WIDTH;
    localparam int VLD_BIT = REQ_W - 1;
    localparam int WR_BIT  = REQ_W - 2;
    localparam int TILE_HI = DATA_WIDTH + ADDR_WIDTH - 1;

    logic dma_vld;
    logic dma_hit;
    logic rtr_hit_vld;
    logic dma_acc;

    // Source of the request currently on bank_req: 0 = DMA, 1 = router.
    logic                  bank_src_p0;
    // Read-tag pipe aligned with the bank's read latency.
    logic [RD_LATENCY-1:0] tag_vld_p;
    logic [RD_LATENCY-1:0] tag_src_p;

    // Hit detection and DMA handshake; the router always wins the bank.
    always_comb begin
        dma_vld       = dma_req[VLD_BIT];
        dma_hit       = (dma_req[TILE_HI -: TILE_SEL_ADDR_WIDTH] == glb_tile_id);
        rtr_hit_vld   = rtr_req[VLD_BIT] &
                        (rtr_req[TILE_HI -: TILE_SEL_ADDR_WIDTH] == glb_tile_id);
        dma_req_ready = clk_en & ~reset & ~(rtr_hit_vld & dma_hit);
        dma_acc       = dma_vld & dma_req_ready;
    end

    // Register the forwarded miss and the winning bank access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_req     <= '0;
            bank_req    <= '0;
            bank_src_p0 <= 1'b0;
        end else if (clk_en) begin
            fwd_req <= (dma_acc & ~dma_hit) ? dma_req : '0;
            if (rtr_hit_vld) begin
                bank_req    <= rtr_req;
                bank_src_p0 <= 1'b1;
            end else if (dma_acc & dma_hit) begin
                bank_req    <= dma_req;
                bank_src_p0 <= 1'b0;
            end else begin
                bank_req    <= '0;
                bank_src_p0 <= 1'b0;
            end
        end
    end

    // Shift read tags so the tail lines up with bank_rd_data; writes push no tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_p <= '0;
            tag_src_p <= '0;
        end else if (clk_en) begin
            tag_vld_p[0] <= bank_req[VLD_BIT] & ~bank_req[WR_BIT];
            tag_src_p[0] <= bank_src_p0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_src_p[i] <= tag_src_p[i-1];
            end
        end
    end

    // Steer returning bank data to the requester named by the tail tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_rsp <= '0;
            rtr_rsp <= '0;
        end else if (clk_en) begin
            dma_rsp <= (tag_vld_p[RD_LATENCY-1] & ~tag_src_p[RD_LATENCY-1])
                       ? {1'b1, bank_rd_data} : '0;
            rtr_rsp <= (tag_vld_p[RD_LATENCY-1] &  tag_src_p[RD_LATENCY-1])
                       ? {1'b1, bank_rd_data} : '0;
        end
    end

`ifdef GLB_STRM_SWITCH_PERF_CNT_EN
    // Count cycles where a valid DMA hit loses the bank to the router; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
        end else if (clk_en & dma_vld & dma_hit & rtr_hit_vld) begin
            if (perf_conflict_cnt != 32'hFFFF_FFFF) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
